// File: rtl/mips32_pkg.sv
// Shared MIPS32 front-end constants and the fetch buffer entry type.
package mips32_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Clear the byte-offset bits so the address points at a whole word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order buffer of fetched {pc, instr} entries between imem and decode.
module fetch_fifo
    import mips32_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   do_push;
    logic                   do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A flush cancels any push/pop presented in the same cycle.
    assign do_push = push & ~flush;
    assign do_pop  = pop  & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetch PC, imem request/handshake, redirect flush, 2-entry buffer.
module instr_fetch
    import mips32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_current,
    output logic [31:0] pc4
);

    logic [31:0]  fpc;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    // Redirect outranks everything: no consume and no capture while flushing.
    assign pop      = ~empty & ~stall & ~redirect;
    assign imem_req = ~reset & (~full | pop);
    assign push     = imem_req & imem_ack & ~redirect;
    assign imem_addr = fpc;

    assign push_entry.pc    = fpc;
    assign push_entry.instr = imem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc <= RESET_PC;
        end else if (redirect) begin
            fpc <= word_align(redirect_pc);
        end else if (push) begin
            fpc <= fpc + 32'(WORD_BYTES);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .full       (full),
        .empty      (empty),
        .head       (head)
    );

    // Outputs depend only on buffer state, never on imem_rdata.
    assign instr_valid = ~empty;
    assign instr       = empty ? INSTR_NOP : head.instr;
    assign pc_current  = empty ? 32'h0 : head.pc;
    assign pc4         = empty ? 32'h0 : head.pc + 32'(WORD_BYTES);

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a queue-based fetch model.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_current;
    logic [31:0] pc4;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_fpc;

    instr_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc_current  (pc_current),
        .pc4         (pc4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model's view of the buffer head.
    task automatic check_outputs(input string tag);
        bit have = (q.size() > 0);
        bit pop  = have && !stall && !redirect;
        check({tag, ".req"},   32'(imem_req), 32'((q.size() < 2) || pop));
        check({tag, ".addr"},  imem_addr, m_fpc);
        check({tag, ".valid"}, 32'(instr_valid), 32'(have));
        check({tag, ".instr"}, instr,      have ? q[0].ins : 32'h0);
        check({tag, ".pc"},    pc_current, have ? q[0].pc  : 32'h0);
        check({tag, ".pc4"},   pc4,        have ? q[0].pc + 32'd4 : 32'h0);
    endtask

    // One clock: drive inputs after negedge, check, advance model, cross posedge.
    task automatic step(input string tag, input bit s, input bit r, input logic [31:0] rpc,
                        input bit a, input logic [31:0] rd);
        bit pop;
        bit req;
        stall = s; redirect = r; redirect_pc = rpc; imem_ack = a; imem_rdata = rd;
        #1;
        check_outputs(tag);
        pop = (q.size() > 0) && !s && !r;
        req = (q.size() < 2) || pop;
        if (r) begin
            q.delete();
            m_fpc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(q.pop_front());
            if (req && a) begin
                q.push_back({m_fpc, rd});
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset asserted in the middle of a cycle while a transfer is presented.
    task automatic mid_reset(input string tag);
        stall = 1'b1; redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        m_fpc = RST_PC;
        check({tag, ".rst_valid"}, 32'(instr_valid), 32'h0);
        check({tag, ".rst_instr"}, instr, 32'h0);
        check({tag, ".rst_pc"},    pc_current, 32'h0);
        check({tag, ".rst_pc4"},   pc4, 32'h0);
        check({tag, ".rst_req"},   32'(imem_req), 32'h0);
        check({tag, ".rst_addr"},  imem_addr, RST_PC);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".rst_hold_req"}, 32'(imem_req), 32'h0);
        reset = 1'b0;
        stall = 1'b0;
        #1;
        check({tag, ".rel_addr"}, imem_addr, RST_PC);
        check({tag, ".rel_req"},  32'(imem_req), 32'h1);
    endtask

    initial begin
        m_fpc = RST_PC;
        @(negedge clk);
        #1;
        check("reset.valid", 32'(instr_valid), 32'h0);
        check("reset.req",   32'(imem_req), 32'h0);
        check("reset.instr", instr, 32'h0);
        check("reset.addr",  imem_addr, RST_PC);
        @(negedge clk);
        reset = 1'b0;

        // Streaming with continuous ack
        for (int i = 0; i < 6; i++) step("stream", 0, 0, '0, 1, m_fpc | 32'hA000_0000);
        // Stall with ack held: buffer fills and request drops
        for (int i = 0; i < 4; i++) step("stall", 1, 0, '0, 1, m_fpc | 32'hA000_0000);
        for (int i = 0; i < 4; i++) step("release", 0, 0, '0, 1, m_fpc | 32'hA000_0000);
        // Redirect to an unaligned target
        step("redir", 0, 1, 32'h0000_0103, 1, m_fpc | 32'hA000_0000);
        check("redir.addr", imem_addr, 32'h0000_0100);
        for (int i = 0; i < 3; i++) step("post_redir", 0, 0, '0, 1, m_fpc | 32'hA000_0000);
        // Back-to-back redirects; the last wins
        step("redir2a", 0, 1, 32'h0000_2000, 1, 32'h1111_1111);
        step("redir2b", 0, 1, 32'h0000_3006, 1, 32'h2222_2222);
        // Memory wait states
        for (int i = 0; i < 3; i++) step("wait", 0, 0, '0, 0, 32'h3333_3333);
        for (int i = 0; i < 3; i++) step("ackd", 0, 0, '0, 1, m_fpc | 32'hA000_0000);
        // Address wrap at the top of memory
        step("wrap_redir", 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
        for (int i = 0; i < 4; i++) step("wrap", 0, 0, '0, 1, m_fpc | 32'hA000_0000);
        // Async reset with one entry buffered
        step("pre_rst", 0, 1, 32'h0000_0040, 1, 32'h0);
        step("one_ent", 1, 0, '0, 1, 32'h4444_4444);
        mid_reset("midrst");
        for (int i = 0; i < 3; i++) step("after_rst", 0, 0, '0, 1, m_fpc | 32'hA000_0000);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                mid_reset("rnd_rst");
            end else begin
                step("rnd",
                     $urandom_range(0, 9) < 3,
                     $urandom_range(0, 9) == 0,
                     $urandom(),
                     $urandom_range(0, 9) < 6,
                     $urandom());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
